seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
- Sequential unsigned restoring divider, WIDTH-bit dividend / WIDTH-bit divisor.
- Inverse companion to the multiplier datapath. Reuses the existing 16-bit CLA adder as the trial subtractor.
- Produces one quotient bit per clock, with a start/busy/done handshake toward the surrounding arithmetic unit.

Parameters:
- WIDTH, 16, operand/quotient/remainder width.
- CNT_W, 5, iteration counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled on rising clk edge, honoured only when busy=0.
- dividend  input  WIDTH  numerator; latched on accepted start.
- divisor  input  WIDTH  denominator; latched on accepted start.
- busy  output  1  high while a division is in progress.
- done  output  1  one-cycle pulse; results valid from this cycle onward.
- quotient  output  WIDTH  result; held until the next accepted start.
- remainder  output  WIDTH  result; held until the next accepted start.
- div_by_zero  output  1  set with done when divisor==0; cleared on next accepted start.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, counter=0, internal registers=0.
- Reset asserted mid-division aborts the operation immediately. No done is issued for the aborted operation.
- States: IDLE, RUN, FIN.
- IDLE, start=1 at edge k:
  - Latch operands. Partial remainder R (WIDTH+1 bits)=0. Q=dividend. Counter=0. Clear div_by_zero.
  - If divisor!=0: go RUN, busy=1 from edge k.
  - If divisor==0: go FIN directly with quotient=all ones, remainder=dividend, div_by_zero=1.
- RUN, each cycle:
  - T = {R[WIDTH-1:0], Q[WIDTH-1]} - {1'b0, divisor}, computed at WIDTH+1 bits.
  - No borrow: R=T, shift Q left inserting 1.
  - Borrow: R={R[WIDTH-1:0], Q[WIDTH-1]}, shift Q left inserting 0.
  - Counter increments. After the WIDTH-th iteration (counter==WIDTH-1), go FIN.
- FIN (one cycle):
  - quotient=Q, remainder=R[WIDTH-1:0], done=1, busy=0.
  - Next edge returns to IDLE with done=0.
- Latency:
  - Nonzero divisor: start accepted at edge k gives done high in the cycle after edge k+WIDTH+1 (k+17 for WIDTH=16).
  - Divide-by-zero: done high after edge k+1.
- Handshake:
  - start while busy=1 is ignored, including in RUN; operands are not re-latched.
  - start during the FIN cycle is also ignored; it is accepted from IDLE only.
  - done is never asserted twice for one start.
- Operand changes after acceptance have no effect.
- Invariant at done with div_by_zero=0: quotient*divisor + remainder == dividend, and remainder < divisor.
- Boundaries:
  - dividend < divisor gives quotient=0, remainder=dividend.
  - divisor=1 gives quotient=dividend, remainder=0.
  - Max operands: no overflow, since R is WIDTH+1 bits.

Decomposition:
- Shared arithmetic package:
  - state encoding constants IDLE=2'd0, RUN=2'd1, FIN=2'd2;
  - default WIDTH=16;
  - DIV0_QUOTIENT = all ones.
- One natural sub-module: div_step.
  - Combinational, takes R, Q msb and divisor; returns next R, quotient bit and borrow.
  - Builds its WIDTH+1 subtraction from the existing CLA adder (in2 = ~divisor, cin=1, cout=1 means no borrow), extended by one bit.
- FSM, counter and output registers stay in seq_divider.

Test Plan:
- Reset then idle: rst_n=0 for 3 cycles -> all outputs 0. Release, no start -> outputs stay 0, busy=0.
- Nominal: dividend=100, divisor=7, start at edge k -> busy 1 from k, done pulse after edge k+17, quotient=14, remainder=2, div_by_zero=0.
- Extremes:
  - 0xFFFF/1 -> q=0xFFFF, r=0.
  - 0xFFFF/0xFFFF -> q=1, r=0.
  - 3/10 -> q=0, r=3.
  - 0x7FFF/0x0100 -> q=0x007F, r=0x00FF.
- Divide-by-zero: dividend=5, divisor=0 -> done after edge k+1, div_by_zero=1, q=0xFFFF, r=5. A following 20/4 clears the flag and gives q=5, r=0.
- Handshake:
  - Start 100/7, then pulse start with 9/3 at k+5 -> ignored; single done, q=14, r=2.
  - Back-to-back start in the cycle after done is accepted.
- Abort: start 1000/3, drop rst_n at k+8 (between edges) -> outputs clear immediately and no done appears. After release, 1000/3 -> q=333, r=1.

Source files
------------

// File: rtl/seq_divider_pkg.sv
// Shared arithmetic definitions for the sequential divider: FSM encoding and
// the defaults used by the divider datapath.
package seq_divider_pkg;

    localparam int DEFAULT_WIDTH = 16;

    // Wide enough to cover any WIDTH; callers truncate to their operand width.
    localparam logic [63:0] DIV0_QUOTIENT = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_e;

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: shift in the next dividend bit and
// try to subtract the divisor with a generate/propagate carry-lookahead adder.
module div_step
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             qMsb_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] remNext_o,
    output logic             qBit_o
);

    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] invDivisor;
    logic [WIDTH-1:0] gen;
    logic [WIDTH-1:0] prop;
    logic [WIDTH-1:0] diff;
    logic [WIDTH:0]   carry;
    logic             noBorrow;

    // Subtract as shifted + ~divisor + 1; the extra top bit of the WIDTH+1
    // trial value is handled by folding it into the final carry-out.
    always_comb begin
        shifted    = {rem_i[WIDTH-2:0], qMsb_i};
        invDivisor = ~divisor_i;
        gen        = shifted & invDivisor;
        prop       = shifted ^ invDivisor;
        carry      = '0;
        carry[0]   = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            carry[i+1] = gen[i] | (prop[i] & carry[i]);
        end
        diff      = prop ^ carry[WIDTH-1:0];
        noBorrow  = rem_i[WIDTH-1] | carry[WIDTH];
        remNext_o = noBorrow ? diff : shifted;
        qBit_o    = noBorrow;
    end

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider with start/busy/done handshake,
// producing one quotient bit per clock.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             div_by_zero_o
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] stepRem;
    logic             stepQBit;

    // The partial remainder always stays below the divisor, so its extra
    // top bit is never set and only WIDTH bits are stored.
    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .qMsb_i    (quo_q[WIDTH-1]),
        .divisor_i (dvsr_q),
        .remNext_o (stepRem),
        .qBit_o    (stepQBit)
    );

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvsr_d      = dvsr_q;
        zero_d      = zero_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    dvsr_d  = divisor_i;
                    count_d = '0;
                    dbz_d   = 1'b0;
                    if (divisor_i == '0) begin
                        quo_d   = WIDTH'(DIV0_QUOTIENT);
                        rem_d   = dividend_i;
                        zero_d  = 1'b1;
                        state_d = FIN;
                    end else begin
                        quo_d   = dividend_i;
                        rem_d   = '0;
                        zero_d  = 1'b0;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                rem_d   = stepRem;
                quo_d   = {quo_q[WIDTH-2:0], stepQBit};
                count_d = count_q + CNT_W'(1);
                if (count_q == CNT_W'(WIDTH - 1)) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                quotient_d  = quo_q;
                remainder_d = rem_q;
                dbz_d       = zero_q;
                done_d      = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvsr_q      <= '0;
            zero_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvsr_q      <= dvsr_d;
            zero_q      <= zero_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            done_q      <= done_d;
        end
    end

    assign busy_o        = (state_q == RUN);
    assign done_o        = done_q;
    assign quotient_o    = quotient_q;
    assign remainder_o   = remainder_q;
    assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: hand-computed quotients/remainders, done
// latency, handshake rules and reset abort.
module tb_seq_divider;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        dbz;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seq_divider #(.WIDTH(16), .CNT_W(5)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start),
        .dividend_i    (dividend),
        .divisor_i     (divisor),
        .busy_o        (busy),
        .done_o        (done),
        .quotient_o    (quotient),
        .remainder_o   (remainder),
        .div_by_zero_o (dbz)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Drive a start in the cycle before edge k; returns 1ns after edge k with
    // the operand pins scrambled so late operand changes are exercised.
    task automatic applyStimulus(input logic [15:0] dvd, input logic [15:0] dvs);
        @(negedge clk);
        start    = 1'b1;
        dividend = dvd;
        divisor  = dvs;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = 16'hDEAD;
        divisor  = 16'hBEEF;
    endtask

    task automatic waitDone(output int cycles);
        cycles = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                cycles = n;
                break;
            end
        end
    endtask

    task automatic runAndCheck(input string tag, input logic [15:0] dvd, input logic [15:0] dvs,
                               input logic [15:0] expQ, input logic [15:0] expR,
                               input int expLat, input logic expDbz);
        int lat;
        applyStimulus(dvd, dvs);
        checkOutput({tag, ".busy"}, {31'd0, busy}, {31'd0, (dvs != 16'd0)});
        checkOutput({tag, ".dbzClr"}, {31'd0, dbz}, 32'd0);
        waitDone(lat);
        checkOutput({tag, ".latency"}, lat, expLat);
        checkOutput({tag, ".q"}, {16'd0, quotient}, {16'd0, expQ});
        checkOutput({tag, ".r"}, {16'd0, remainder}, {16'd0, expR});
        checkOutput({tag, ".dbz"}, {31'd0, dbz}, {31'd0, expDbz});
        checkOutput({tag, ".busyAtDone"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic countDones(input int cycles, output int seen);
        seen = 0;
        for (int n = 0; n < cycles; n++) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
    endtask

    initial begin
        int seen;
        int lat;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = 16'd0;
        divisor  = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst.busy", {31'd0, busy}, 32'd0);
        checkOutput("rst.done", {31'd0, done}, 32'd0);
        checkOutput("rst.q", {16'd0, quotient}, 32'd0);
        checkOutput("rst.r", {16'd0, remainder}, 32'd0);
        checkOutput("rst.dbz", {31'd0, dbz}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        countDones(4, seen);
        checkOutput("idle.done", seen, 0);
        checkOutput("idle.busy", {31'd0, busy}, 32'd0);

        runAndCheck("nominal", 16'd100, 16'd7, 16'd14, 16'd2, 17, 1'b0);
        countDones(5, seen);
        checkOutput("nominal.singleDone", seen, 0);

        runAndCheck("ffff_1", 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 17, 1'b0);
        runAndCheck("ffff_ffff", 16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000, 17, 1'b0);
        runAndCheck("3_10", 16'd3, 16'd10, 16'd0, 16'd3, 17, 1'b0);
        runAndCheck("7fff_100", 16'h7FFF, 16'h0100, 16'h007F, 16'h00FF, 17, 1'b0);

        // Divide by zero, then a back-to-back start issued in the done cycle.
        runAndCheck("div0", 16'd5, 16'd0, 16'hFFFF, 16'd5, 1, 1'b1);
        runAndCheck("after0", 16'd20, 16'd4, 16'd5, 16'd0, 17, 1'b0);
        countDones(3, seen);
        checkOutput("after0.singleDone", seen, 0);

        // A second start during RUN must be ignored.
        applyStimulus(16'd100, 16'd7);
        repeat (4) @(posedge clk);
        #1;
        start    = 1'b1;
        dividend = 16'd9;
        divisor  = 16'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("ignore.busy", {31'd0, busy}, 32'd1);
        waitDone(lat);
        checkOutput("ignore.latency", lat, 12);
        checkOutput("ignore.q", {16'd0, quotient}, 32'd14);
        checkOutput("ignore.r", {16'd0, remainder}, 32'd2);
        countDones(25, seen);
        checkOutput("ignore.singleDone", seen, 0);

        // Reset between edges aborts the division without a done.
        applyStimulus(16'd1000, 16'd3);
        repeat (8) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("abort.busy", {31'd0, busy}, 32'd0);
        checkOutput("abort.q", {16'd0, quotient}, 32'd0);
        checkOutput("abort.r", {16'd0, remainder}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        countDones(20, seen);
        checkOutput("abort.noDone", seen, 0);
        runAndCheck("rerun", 16'd1000, 16'd3, 16'd333, 16'd1, 17, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
